// File: rtl/secuenciador_registros.sv
// Purpose : sequences RTC read/write sweeps over the ten time/date/timer registers
//           and routes user edit mode onto the register bank hold/select lines.
// Latency : all outputs registered; a pending request starts a sweep on the next edge.
// Backpr. : each RTC transaction holds rtc_req until the single-cycle rtc_listo ack.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   modo_edicion    user edit mode (level)
//   campo_edicion   field under edit, 0..9 (10..15 select nothing)
//   escribir        one-cycle pulse requesting a write sweep
//   rtc_listo       one-cycle ack from the RTC bus interface
//   rtc_req         transaction request, held until rtc_listo
//   rtc_escritura   1 = write, 0 = read (valid while rtc_req)
//   rtc_dir         RTC register address (valid while rtc_req)
//   cs_vec          per-register chip selects (capture pulse or edit select)
//   hold_vec        per-register source select, 1 = local counter
//   ocupado         high while a sweep is in progress
module secuenciador_registros #(
    parameter int PERIODO = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       modo_edicion,
    input  logic [3:0] campo_edicion,
    input  logic       escribir,
    input  logic       rtc_listo,
    output logic       rtc_req,
    output logic       rtc_escritura,
    output logic [7:0] rtc_dir,
    output logic [9:0] cs_vec,
    output logic [9:0] hold_vec,
    output logic       ocupado
);

    localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam logic [CW-1:0] TICK_MAX = CW'(PERIODO - 1);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        LEER     = 2'd1,
        CAPTURA  = 2'd2,
        ESCRIBIR = 2'd3
    } estado_t;

    // Field index to RTC address: time/date block at 0x21.., timer block at 0x41..
    function automatic logic [7:0] mapa_dir(input logic [3:0] i);
        logic [7:0] d;
        case (i)
            4'd0:    d = 8'h21;
            4'd1:    d = 8'h22;
            4'd2:    d = 8'h23;
            4'd3:    d = 8'h24;
            4'd4:    d = 8'h25;
            4'd5:    d = 8'h26;
            4'd6:    d = 8'h27;
            4'd7:    d = 8'h41;
            4'd8:    d = 8'h42;
            4'd9:    d = 8'h43;
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    estado_t       estado, estado_sig;
    logic [3:0]    idx, idx_sig;
    logic [CW-1:0] cnt;
    logic          pend_lectura, pend_escritura;
    logic          clr_lectura, clr_escritura;
    logic          tick;
    logic          ack;
    logic [9:0]    captura_oh;
    logic [9:0]    edicion_oh;
    logic          req_sig;
    logic          escritura_sig;
    logic [7:0]    dir_sig;
    logic [9:0]    cs_sig;

    assign tick = (cnt == TICK_MAX);

    // An ack only counts while a request is actually outstanding; this also
    // ignores stray acks during the one-cycle gap between write fields.
    assign ack = rtc_listo & rtc_req;

    always_comb begin
        estado_sig    = estado;
        idx_sig       = idx;
        clr_lectura   = 1'b0;
        clr_escritura = 1'b0;
        captura_oh    = '0;
        case (estado)
            REPOSO: begin
                if (pend_escritura) begin
                    estado_sig    = ESCRIBIR;
                    idx_sig       = 4'd0;
                    clr_escritura = 1'b1;
                end else if (pend_lectura && !modo_edicion) begin
                    estado_sig  = LEER;
                    idx_sig     = 4'd0;
                    clr_lectura = 1'b1;
                end
            end
            LEER: begin
                if (ack) begin
                    estado_sig = CAPTURA;
                    captura_oh = 10'd1 << idx;
                end
            end
            CAPTURA: begin
                if (idx == 4'd9) begin
                    estado_sig = REPOSO;
                    idx_sig    = 4'd0;
                end else begin
                    estado_sig = LEER;
                    idx_sig    = idx + 4'd1;
                end
            end
            ESCRIBIR: begin
                if (ack) begin
                    if (idx == 4'd9) begin
                        estado_sig = REPOSO;
                        idx_sig    = 4'd0;
                    end else begin
                        idx_sig = idx + 4'd1;
                    end
                end
            end
            default: begin
                estado_sig = REPOSO;
                idx_sig    = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the next-state view so that the request,
    // address and busy flag change on the same edge as the state itself.
    // In a write sweep the acked cycle forces one idle request cycle before
    // the next field.
    always_comb begin
        req_sig       = (estado_sig == LEER) ||
                        ((estado_sig == ESCRIBIR) && !((estado == ESCRIBIR) && ack));
        escritura_sig = req_sig && (estado_sig == ESCRIBIR);
        dir_sig       = req_sig ? mapa_dir(idx_sig) : 8'h00;
    end

    // The edited register keeps counting locally: its select is forced high and
    // any read capture aimed at it is dropped.
    always_comb begin
        edicion_oh = '0;
        if (modo_edicion && (campo_edicion <= 4'd9)) begin
            edicion_oh = 10'd1 << campo_edicion;
        end
        cs_sig = (captura_oh & ~edicion_oh) | edicion_oh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado         <= REPOSO;
            idx            <= 4'd0;
            cnt            <= '0;
            pend_lectura   <= 1'b0;
            pend_escritura <= 1'b0;
            rtc_req        <= 1'b0;
            rtc_escritura  <= 1'b0;
            rtc_dir        <= 8'h00;
            cs_vec         <= '0;
            hold_vec       <= '0;
            ocupado        <= 1'b0;
        end else begin
            estado <= estado_sig;
            idx    <= idx_sig;
            cnt    <= tick ? '0 : cnt + 1'b1;
            // A new request arriving on the same edge a sweep consumes the old
            // one stays pending; repeated ticks while pending merge into one.
            pend_lectura   <= tick | (pend_lectura & ~clr_lectura);
            pend_escritura <= escribir | (pend_escritura & ~clr_escritura);
            rtc_req        <= req_sig;
            rtc_escritura  <= escritura_sig;
            rtc_dir        <= dir_sig;
            cs_vec         <= cs_sig;
            hold_vec       <= edicion_oh;
            ocupado        <= (estado_sig != REPOSO);
        end
    end

endmodule
